irq_encoder_83: RTL and testbench
=================================

// Module: irq_encoder_83
// PURPOSE
//   Inverse of the 3-to-8 decoder: captures 8 one-hot request lines and encodes them to a 3-bit index.
//   Holds an 8-bit pending set and presents the highest-priority unmasked pending request as code/valid.
//   Keeps each presented code stable until the consumer (CP0 cause/exception logic) acknowledges it.
//   Sits between external/peripheral interrupt lines and the pipeline's exception stage.
// PARAMETERS
//   N            8   number of request lines; fixed at 8 for this revision
//   W            3   index width, log2(N)
//   LOW_FIRST    1   1: bit 0 has highest priority; 0: bit N-1 has highest priority
// PORTS
//   clk      in   1  single clock; all state updates on posedge
//   rst_n    in   1  synchronous reset, active-low
//   req      in   8  level request lines; a 0->1 transition sets the pending bit
//   mask     in   8  1 = request eligible for presentation; pending bits stay set while masked
//   ack      in   1  consumer accepts the presented code; honoured only while valid=1
//   code     out  3  index of the presented request; held stable while valid=1
//   valid    out  1  code is meaningful and awaiting ack
//   multi    out  1  more than one request was eligible when code was loaded
//   pending  out  8  current pending set (status/readback)
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): pending=0, req_q=0, code=0, valid=0, multi=0, state=IDLE.
//   - req_q=0 after reset, so a line held high through reset is captured as an edge on the first cycle after reset.
//   Edge capture: rise = req & ~req_q; req_q <= req every cycle.
//   pending update: pending <= (pending & ~clr) | rise.
//   - clr = one-hot(code) when valid & ack, else 0.
//   - Same bit set and cleared in one cycle: set wins; the bit stays pending.
//   eligible = pending & mask, combinational from registered state.
//   FSM states: IDLE, PRESENT.
//   - IDLE: if eligible != 0, load code = priority index of eligible per LOW_FIRST.
//     Also load multi = (more than one eligible bit), set valid=1, go to PRESENT. Otherwise hold valid=0.
//   - PRESENT: code, multi, valid frozen; mask/req changes do not alter them.
//     On ack: valid<=0, clear pending[code], go to IDLE.
//   - Exactly one bubble cycle (valid=0) after every ack, before the next load.
//   Latency: req rises before edge t -> pending set at edge t -> code/valid at edge t+1.
//   - Best case, valid is seen 2 cycles after req rises.
//   ack while valid=0 is ignored; no state change.
//   A request masked after presentation stays presented until ack; ack clears it normally.
//   req falling does not clear pending; only ack clears.
//   Reset mid-PRESENT: everything returns to reset values; the in-flight code is dropped without ack.
//   All outputs are registered; no combinational path from any input to any output.
// STRUCTURE
//   Package irq_pkg:
//   - localparams N=8 and W=3.
//   - State enum {IDLE, PRESENT} (2-bit encoding).
//   - Function onehot_w(idx) returning the N-bit one-hot of idx.
//   Sub-module prio_enc_83: combinational encoder.
//   - in[7:0] -> idx[2:0], any, multi.
//   - LOW_FIRST parameter passed through; the reverse function of the 3-to-8 decoder.
//   Top level: req_q/pending registers, FSM, output registers.
// TESTING
//   1 Reset with req=8'hFF, mask=8'hFF; release rst_n.
//     -> valid=1 with code=0 two cycles later; multi=1; pending=8'hFF.
//   2 Single req[5] pulse with mask=8'hFF, then ack on the first valid cycle.
//     -> code=5, multi=0; after ack: valid=0 and pending[5]=0.
//   3 req[2] and req[6] rise together.
//     -> code=2, then a one-cycle bubble, then code=6; LOW_FIRST=0 gives code=6 first.
//   4 While code=3 is presented, set mask=8'h00 and raise req[1].
//     -> code stays 3 until ack; then valid stays 0; pending=8'h02.
//     -> Restore mask: code=1 appears after 1 cycle.
//   5 ack while valid=0, and ack on the same cycle that req[code] re-rises.
//     -> first is ignored; second leaves the bit pending and it is re-presented after the bubble.
//   6 Assert rst_n=0 while valid=1 with pending=8'h30.
//     -> next cycle: valid=0, code=0, multi=0, pending=0.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and helpers for the 8-line interrupt request encoder.
// Line count and index width are fixed at 8 and 3 for this revision.
package irq_pkg;

   localparam int N = 8;
   localparam int W = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1
   } state_t;

   function automatic logic [N-1:0] onehot_w(input logic [W-1:0] idx);
      logic [N-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/prio_enc_83.sv
// Combinational 8-to-3 priority encoder, the reverse of a 3-to-8 decoder.
// It also reports whether any input bit is set and whether more than one is set.
module prio_enc_83
   import irq_pkg::*;
#(
   parameter bit LOW_FIRST = 1'b1
) (
   input  logic [N-1:0] in,
   output logic [W-1:0] idx,
   output logic         any,
   output logic         multi
);

   always_comb begin
      idx = '0;
      if (LOW_FIRST) begin
         // Scan downwards so the lowest set bit is the last one written.
         for (int i = N - 1; i >= 0; i--) begin
            if (in[i]) idx = W'(i);
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (in[i]) idx = W'(i);
         end
      end
   end

   assign any   = |in;
   assign multi = |(in & (in - N'(1)));

endmodule

// File: rtl/irq_encoder_83.sv
// Captures rising edges on 8 request lines into a pending set and presents the
// highest-priority unmasked pending request as a registered code until acked.
module irq_encoder_83
   import irq_pkg::*;
#(
   parameter bit LOW_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic [N-1:0] mask,
   input  logic         ack,
   output logic [W-1:0] code,
   output logic         valid,
   output logic         multi,
   output logic [N-1:0] pending,
   output logic [1:0]   dbg_state
);

   // Handshake: valid/code/multi hold steady until a cycle with valid=1 and ack=1;
   // that cycle consumes the code, and ack seen while valid=0 has no effect.

   logic [N-1:0] r_req_q;
   logic [N-1:0] r_pending;
   logic [W-1:0] r_code;
   logic         r_valid;
   logic         r_multi;
   state_t       r_state;

   logic [N-1:0] w_rise;
   logic [N-1:0] w_clr;
   logic [N-1:0] w_eligible;
   logic [W-1:0] w_enc_idx;
   logic         w_enc_any;
   logic         w_enc_multi;
   logic         w_take;
   state_t       w_state_nxt;
   logic [W-1:0] w_code_nxt;
   logic         w_valid_nxt;
   logic         w_multi_nxt;

   assign w_take     = r_valid & ack;
   assign w_rise     = req & ~r_req_q;
   assign w_clr      = w_take ? onehot_w(r_code) : '0;
   assign w_eligible = r_pending & mask;

   prio_enc_83 #(.LOW_FIRST(LOW_FIRST)) u_enc (
      .in    (w_eligible),
      .idx   (w_enc_idx),
      .any   (w_enc_any),
      .multi (w_enc_multi)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_code_nxt  = r_code;
      w_valid_nxt = r_valid;
      w_multi_nxt = r_multi;
      case (r_state)
         IDLE: begin
            if (w_enc_any) begin
               w_code_nxt  = w_enc_idx;
               w_multi_nxt = w_enc_multi;
               w_valid_nxt = 1'b1;
               w_state_nxt = PRESENT;
            end else begin
               w_valid_nxt = 1'b0;
            end
         end
         PRESENT: begin
            // Returning to IDLE first guarantees one bubble cycle before the next load.
            if (w_take) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_valid_nxt = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_req_q   <= '0;
         r_pending <= '0;
         r_code    <= '0;
         r_valid   <= 1'b0;
         r_multi   <= 1'b0;
         r_state   <= IDLE;
      end else begin
         r_req_q   <= req;
         // A bit rising in the same cycle it is cleared stays pending.
         r_pending <= (r_pending & ~w_clr) | w_rise;
         r_code    <= w_code_nxt;
         r_valid   <= w_valid_nxt;
         r_multi   <= w_multi_nxt;
         r_state   <= w_state_nxt;
      end
   end

   assign code      = r_code;
   assign valid     = r_valid;
   assign multi     = r_multi;
   assign pending   = r_pending;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_irq_encoder_83.sv
// Directed bench for irq_encoder_83: low-first and high-first instances share stimulus;
// every step is checked against hand-derived values.
module tb_irq_encoder_83;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] mask;
   logic       ack;

   logic [2:0] code,    hf_code;
   logic       valid,   hf_valid;
   logic       multi,   hf_multi;
   logic [7:0] pending, hf_pending;
   logic [1:0] dbg_state, hf_dbg_state;

   int n_vec  = 0;
   int n_fail = 0;

   irq_encoder_83 #(.LOW_FIRST(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .mask      (mask),
      .ack       (ack),
      .code      (code),
      .valid     (valid),
      .multi     (multi),
      .pending   (pending),
      .dbg_state (dbg_state)
   );

   irq_encoder_83 #(.LOW_FIRST(1'b0)) dut_hf (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .mask      (mask),
      .ack       (ack),
      .code      (hf_code),
      .valid     (hf_valid),
      .multi     (hf_multi),
      .pending   (hf_pending),
      .dbg_state (hf_dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1 time unit before driving/checking.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic v, input logic [2:0] c,
                            input logic m, input logic [7:0] p);
      check({tag, ".valid"},   {7'd0, valid}, {7'd0, v});
      check({tag, ".code"},    {5'd0, code},  {5'd0, c});
      check({tag, ".multi"},   {7'd0, multi}, {7'd0, m});
      check({tag, ".pending"}, pending,       p);
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 8'hFF;
      mask  = 8'hFF;
      ack   = 1'b0;

      // 1: lines held high through reset are captured after release
      tick();
      tick();
      check_out("t1.reset", 1'b0, 3'd0, 1'b0, 8'h00);
      check("t1.reset.state", {6'd0, dbg_state}, 8'h00);
      rst_n = 1'b1;
      tick();
      check_out("t1.capture", 1'b0, 3'd0, 1'b0, 8'hFF);
      tick();
      check_out("t1.present", 1'b1, 3'd0, 1'b1, 8'hFF);
      check("t1.state", {6'd0, dbg_state}, 8'h01);
      check("t1.hf.code", {5'd0, hf_code}, 8'h07);

      // 2: single pulse on req[5], ack on first valid cycle
      rst_n = 1'b0;
      req   = 8'h00;
      tick();
      rst_n = 1'b1;
      tick();
      req = 8'h20;
      tick();
      req = 8'h00;
      check_out("t2.pend", 1'b0, 3'd0, 1'b0, 8'h20);
      tick();
      check_out("t2.present", 1'b1, 3'd5, 1'b0, 8'h20);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check_out("t2.acked", 1'b0, 3'd5, 1'b0, 8'h00);
      check("t2.state", {6'd0, dbg_state}, 8'h00);

      // 3: req[2] and req[6] together; bubble between presentations
      req = 8'h44;
      tick();
      req = 8'h00;
      tick();
      check_out("t3.first", 1'b1, 3'd2, 1'b1, 8'h44);
      check("t3.hf.first", {5'd0, hf_code}, 8'h06);
      check("t3.hf.valid", {7'd0, hf_valid}, 8'h01);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check_out("t3.bubble", 1'b0, 3'd2, 1'b1, 8'h40);
      check("t3.hf.bubble", {7'd0, hf_valid}, 8'h00);
      tick();
      check_out("t3.second", 1'b1, 3'd6, 1'b0, 8'h40);
      check("t3.hf.second", {5'd0, hf_code}, 8'h02);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check_out("t3.done", 1'b0, 3'd6, 1'b0, 8'h00);

      // 4: mask drops while code 3 is presented
      req = 8'h08;
      tick();
      req = 8'h00;
      tick();
      check_out("t4.present", 1'b1, 3'd3, 1'b0, 8'h08);
      mask = 8'h00;
      req  = 8'h02;
      tick();
      req = 8'h00;
      check_out("t4.frozen", 1'b1, 3'd3, 1'b0, 8'h0A);
      tick();
      check_out("t4.frozen2", 1'b1, 3'd3, 1'b0, 8'h0A);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check_out("t4.acked", 1'b0, 3'd3, 1'b0, 8'h02);
      tick();
      check_out("t4.masked", 1'b0, 3'd3, 1'b0, 8'h02);
      mask = 8'hFF;
      tick();
      check_out("t4.unmasked", 1'b1, 3'd1, 1'b0, 8'h02);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check_out("t4.done", 1'b0, 3'd1, 1'b0, 8'h00);

      // 5: stray ack ignored; ack coinciding with re-rise keeps the bit
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check_out("t5.stray", 1'b0, 3'd1, 1'b0, 8'h00);
      check("t5.stray.state", {6'd0, dbg_state}, 8'h00);
      req = 8'h10;
      tick();
      req = 8'h00;
      tick();
      check_out("t5.present", 1'b1, 3'd4, 1'b0, 8'h10);
      ack = 1'b1;
      req = 8'h10;
      tick();
      ack = 1'b0;
      req = 8'h00;
      check_out("t5.setwins", 1'b0, 3'd4, 1'b0, 8'h10);
      tick();
      check_out("t5.represent", 1'b1, 3'd4, 1'b0, 8'h10);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check_out("t5.done", 1'b0, 3'd4, 1'b0, 8'h00);

      // 6: reset while presenting with pending 8'h30
      req = 8'h30;
      tick();
      req = 8'h00;
      tick();
      check_out("t6.present", 1'b1, 3'd4, 1'b1, 8'h30);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_out("t6.reset", 1'b0, 3'd0, 1'b0, 8'h00);
      check("t6.state", {6'd0, dbg_state}, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
